// File: rtl/rob_commit_unit_pkg.sv
// Shared types for the ROB commit stage.
//   rob_entry_t        : ROB head entry as seen by the commit stage
//   commit_state_e     : commit FSM states (RUN, FLUSH)
//   rvfi_mem_signals_t : memory fields forwarded on the RVFI trace port
//                        (only used when COMMIT_RVFI_EN is defined)
package rob_commit_unit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PHYS_REGS = 64;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PTAG_W    = $clog2(PHYS_REGS);

  typedef logic [PTAG_W-1:0] ptag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        flush;
    logic [4:0]  rd;
    ptag_t       pd;
    ptag_t       old_pd;
    logic        regf_we;
    logic        is_store;
  } rob_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } rvfi_mem_signals_t;

endpackage

// File: rtl/rob_commit_unit_flush_ctrl.sv
// commit_flush_ctrl: RUN/FLUSH state register and bubble down-counter.
//   clk, rst    : clock, synchronous active-high reset (returns to RUN)
//   flush_req   : the head retiring this cycle is flush-marked
//   in_flush    : FSM is in FLUSH; commit must hold off retirement
//   flush       : one-cycle global flush pulse
module commit_flush_ctrl
  import rob_commit_unit_pkg::*;
#(
  parameter int FLUSH_BUBBLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_req,
  output logic in_flush,
  output logic flush
);

  localparam int CNT_W = $clog2(FLUSH_BUBBLES + 1);

  commit_state_e    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_flush   = 1'b0;
    flush      = 1'b0;
    case (state)
      RUN: begin
        // flush_req is already gated by retirement, which is blocked in FLUSH,
        // so the pulse can never exceed one cycle.
        if (flush_req) begin
          flush      = 1'b1;
          state_next = FLUSH;
          cnt_next   = CNT_W'(FLUSH_BUBBLES);
        end
      end
      FLUSH: begin
        in_flush = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: retires at most one ROB head entry per cycle.
// Optional feature macro: COMMIT_RVFI_EN (adds the RVFI trace outputs).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rob_empty, rob_head_valid     : ROB status / head commit bit
//   rob_head                      : head entry
//   rob_dequeue                   : pop ROB head
//   rrf_we, rrf_rd, rrf_pd        : retirement map write
//   fl_push, fl_pd                : stale physical register back to free list
//   st_release, st_release_rdy    : store release handshake with the LSQ
//   flush, redirect_pc            : one-cycle flush and fetch redirect
//   instret                       : retired-instruction counter
//   rvfi_* (COMMIT_RVFI_EN only)  : retirement trace
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int FLUSH_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_empty,
  input  logic              rob_head_valid,
  input  rob_entry_t        rob_head,
  output logic              rob_dequeue,
  output logic              rrf_we,
  output logic [4:0]        rrf_rd,
  output ptag_t             rrf_pd,
  output logic              fl_push,
  output ptag_t             fl_pd,
  output logic              st_release,
  input  logic              st_release_rdy,
  output logic              flush,
`ifdef COMMIT_RVFI_EN
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_pc_rdata,
  output logic [31:0]       rvfi_pc_wdata,
  output logic [4:0]        rvfi_rd_addr,
  input  rvfi_mem_signals_t rvfi_mem_in,
  output rvfi_mem_signals_t rvfi_mem,
`endif
  output logic [31:0]       redirect_pc,
  output logic [63:0]       instret
);

  logic in_flush;
  logic retire;
  logic reg_write;

  // A store only retires together with its LSQ release, so a blocked
  // release stalls the whole head with no partial side effects.
  assign retire = !rst && !in_flush && !rob_empty && rob_head_valid &&
                  (!rob_head.is_store || st_release_rdy);

  // x0 is never renamed, so neither the map nor the free list is touched.
  assign reg_write = retire && rob_head.regf_we && (rob_head.rd != 5'd0);

  commit_flush_ctrl #(
    .FLUSH_BUBBLES(FLUSH_BUBBLES)
  ) u_flush_ctrl (
    .clk      (clk),
    .rst      (rst),
    .flush_req(retire && rob_head.flush),
    .in_flush (in_flush),
    .flush    (flush)
  );

  always_comb begin
    rob_dequeue = retire;
    rrf_we      = reg_write;
    fl_push     = reg_write;
    rrf_rd      = reg_write ? rob_head.rd     : 5'd0;
    rrf_pd      = reg_write ? rob_head.pd     : '0;
    fl_pd       = reg_write ? rob_head.old_pd : '0;
    st_release  = retire && rob_head.is_store;
    redirect_pc = flush ? rob_head.pc_next : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end

`ifdef COMMIT_RVFI_EN
  always_comb begin
    rvfi_valid    = retire;
    rvfi_order    = instret;
    rvfi_pc_rdata = rob_head.pc;
    rvfi_pc_wdata = rob_head.pc_next;
    rvfi_rd_addr  = (rob_head.regf_we && retire) ? rob_head.rd : 5'd0;
    rvfi_mem      = rvfi_mem_in;
  end
`else
  logic unused_pc;
  assign unused_pc = ^rob_head.pc;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_empty;
  logic        rob_head_valid;
  rob_entry_t  rob_head;
  logic        st_release_rdy;
  logic        rob_dequeue, rrf_we, fl_push, st_release, flush;
  logic [4:0]  rrf_rd;
  ptag_t       rrf_pd, fl_pd;
  logic [31:0] redirect_pc;
  logic [63:0] instret;

  int asserts_done = 0;
  int failures     = 0;

  always #5 clk = ~clk;

  rob_commit_unit #(.FLUSH_BUBBLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rob_empty     (rob_empty),
    .rob_head_valid(rob_head_valid),
    .rob_head      (rob_head),
    .rob_dequeue   (rob_dequeue),
    .rrf_we        (rrf_we),
    .rrf_rd        (rrf_rd),
    .rrf_pd        (rrf_pd),
    .fl_push       (fl_push),
    .fl_pd         (fl_pd),
    .st_release    (st_release),
    .st_release_rdy(st_release_rdy),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .instret       (instret)
  );

  function automatic rob_entry_t mk(input logic [31:0] pc, input logic [31:0] pc_next,
                                    input logic fl, input logic [4:0] rd, input int pd,
                                    input int old_pd, input logic we, input logic st);
    rob_entry_t e;
    e.pc       = pc;
    e.pc_next  = pc_next;
    e.flush    = fl;
    e.rd       = rd;
    e.pd       = ptag_t'(pd);
    e.old_pd   = ptag_t'(old_pd);
    e.regf_we  = we;
    e.is_store = st;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts_done++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".deq"},   rob_dequeue, 0);
    chk({tag, ".rrfwe"}, rrf_we,      0);
    chk({tag, ".flpush"},fl_push,     0);
    chk({tag, ".strel"}, st_release,  0);
    chk({tag, ".flush"}, flush,       0);
    chk({tag, ".rpc"},   redirect_pc, 0);
  endtask

  initial begin
    rst            = 1'b1;
    rob_empty      = 1'b1;
    rob_head_valid = 1'b0;
    rob_head       = '0;
    st_release_rdy = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    #1;
    chk_idle("reset");
    chk("reset.instret", instret, 0);
    rst = 1'b0;
    #1;
    chk_idle("post_reset_empty");

    // ALU retire: rd5 -> pd12, stale pd3.
    tick();
    rob_empty = 1'b0; rob_head_valid = 1'b1;
    rob_head = mk(32'h1000, 32'h1004, 1'b0, 5'd5, 12, 3, 1'b1, 1'b0);
    #1;
    chk("alu.deq",    rob_dequeue, 1);
    chk("alu.rrfwe",  rrf_we,      1);
    chk("alu.rrfrd",  rrf_rd,      5);
    chk("alu.rrfpd",  rrf_pd,      12);
    chk("alu.flpush", fl_push,     1);
    chk("alu.flpd",   fl_pd,       3);
    chk("alu.strel",  st_release,  0);
    chk("alu.flush",  flush,       0);
    tick();
    chk("alu.instret", instret, 1);

    // x0 write retires but writes nothing.
    rob_head = mk(32'h1004, 32'h1008, 1'b0, 5'd0, 20, 21, 1'b1, 1'b0);
    #1;
    chk("x0.deq",    rob_dequeue, 1);
    chk("x0.rrfwe",  rrf_we,      0);
    chk("x0.flpush", fl_push,     0);
    tick();
    chk("x0.instret", instret, 2);

    // Store with LSQ back-pressure for three cycles.
    rob_head = mk(32'h1008, 32'h100c, 1'b0, 5'd0, 0, 0, 1'b0, 1'b1);
    st_release_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_idle($sformatf("st_stall%0d", i));
      tick();
    end
    chk("st_stall.instret", instret, 2);
    st_release_rdy = 1'b1;
    #1;
    chk("st.deq",   rob_dequeue, 1);
    chk("st.strel", st_release,  1);
    chk("st.rrfwe", rrf_we,      0);
    tick();
    chk("st.instret", instret, 3);
    st_release_rdy = 1'b0;

    // Mispredict: flush pulse, redirect, then two bubbles.
    rob_head = mk(32'h100c, 32'h60000040, 1'b1, 5'd7, 20, 9, 1'b1, 1'b0);
    #1;
    chk("mp.flush", flush,       1);
    chk("mp.rpc",   redirect_pc, 32'h60000040);
    chk("mp.deq",   rob_dequeue, 1);
    chk("mp.rrfwe", rrf_we,      1);
    chk("mp.rrfpd", rrf_pd,      20);
    chk("mp.flpd",  fl_pd,       9);
    tick();
    chk("mp.instret", instret, 4);
    rob_head = mk(32'h60000040, 32'h60000044, 1'b0, 5'd8, 30, 31, 1'b1, 1'b0);
    #1;
    chk_idle("bubble0");
    tick();
    #1;
    chk_idle("bubble1");
    tick();
    #1;
    chk("resume.deq",   rob_dequeue, 1);
    chk("resume.rrfwe", rrf_we,      1);
    chk("resume.flush", flush,       0);
    tick();
    chk("resume.instret", instret, 5);

    // Reset asserted during FLUSH returns to RUN with instret cleared.
    rob_head = mk(32'h2000, 32'h3000, 1'b1, 5'd1, 1, 2, 1'b1, 1'b0);
    #1;
    chk("mp2.flush", flush, 1);
    tick();
    rst = 1'b1;
    rob_head = mk(32'h3000, 32'h3004, 1'b0, 5'd2, 4, 5, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstflush.instret", instret, 0);
    chk("rstflush.deq",     rob_dequeue, 1);
    chk("rstflush.flush",   flush, 0);

    // Back-to-back: four retires in four cycles.
    for (int i = 0; i < 4; i++) begin
      rob_head = mk(32'h4000 + 32'(4 * i), 32'h4004 + 32'(4 * i), 1'b0,
                    5'(i + 10), i + 40, i + 50, 1'b1, 1'b0);
      #1;
      chk($sformatf("b2b%0d.deq", i),  rob_dequeue, 1);
      chk($sformatf("b2b%0d.rrfrd", i), rrf_rd, 64'(i + 10));
      chk($sformatf("b2b%0d.instret_before", i), instret, 64'(i));
      tick();
    end
    chk("b2b.instret", instret, 4);

    // Empty ROB with a stale valid head retires nothing.
    rob_empty = 1'b1;
    #1;
    chk_idle("empty");
    tick();
    chk("empty.instret", instret, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
